// File: rtl/switch_debouncer.sv
// Front-panel switch conditioner: per-bit 2-flop synchroniser and debounce
// counter, producing a stable switch word, a change strobe and a sticky flag.
module switch_debouncer #(
  parameter int  WIDTH           = 8,
  parameter int  DEBOUNCE_CYCLES = 16,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_switches,
  output logic [WIDTH-1:0] switches,
  output logic             changed,
  output logic             event_pending,
  input  logic             ack
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [WIDTH-1:0]            sync1_r;
  logic [WIDTH-1:0]            sync2_r;
  logic [WIDTH-1:0]            switches_r;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_nxt_s;
  logic [WIDTH-1:0]            upd_s;
  logic                        changed_r;
  logic                        pending_r;

  // Two-flop synchroniser for the asynchronous switch levels.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
    end else begin
      sync1_r <= raw_switches;
      sync2_r <= sync1_r;
    end
  end

  // Per-bit debounce decision: a bit updates only after CNT_LAST+1 consecutive
  // differing samples; any agreeing sample discards the partial count.
  always_comb begin
    upd_s     = {WIDTH{1'b0}};
    cnt_nxt_s = {(WIDTH*CNT_W){1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_r[i] == switches_r[i]) begin
        cnt_nxt_s[i] = {CNT_W{1'b0}};
      end else if (cnt_r[i] == CNT_LAST) begin
        upd_s[i]     = 1'b1;
        cnt_nxt_s[i] = {CNT_W{1'b0}};
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Debounced word, counters, change strobe and sticky flag (set beats ack).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      switches_r <= {WIDTH{1'b0}};
      cnt_r      <= {(WIDTH*CNT_W){1'b0}};
      changed_r  <= 1'b0;
      pending_r  <= 1'b0;
    end else begin
      switches_r <= (switches_r & ~upd_s) | (sync2_r & upd_s);
      cnt_r      <= cnt_nxt_s;
      changed_r  <= |upd_s;
      if (|upd_s) begin
        pending_r <= 1'b1;
      end else if (ack) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  assign switches      = switches_r;
  assign changed       = changed_r;
  assign event_pending = pending_r;

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Input-side counterpart to the CPU's display outputs. Conditions the raw 8-bit front-panel switch bank before the CPU reads it on its `switches` input.
- Each bit passes through a 2-flop synchroniser and a per-bit debounce counter.
- Produces a stable switch word, a one-cycle change strobe, and a sticky change flag. The CPU (or a polling loop) clears the flag with an acknowledge handshake.

Parameters:
- WIDTH, 8, number of switch bits.
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised bit must differ from its stable value before the stable value updates (legal range ≥1).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width (derived; do not override).

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- raw_switches  input  WIDTH  asynchronous switch levels.
- switches  output  WIDTH  debounced, registered switch word (drives CPU `switches`).
- changed  output  1  one-cycle pulse; high in the cycle after any bit of `switches` updates.
- event_pending  output  1  sticky flag; set on any update, cleared by `ack`.
- ack  input  1  synchronous clear request for `event_pending`.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is asynchronous and active-high, port `reset`.
- Reset values: `sync1`, `sync2`, `switches`, all counters, `changed` and `event_pending` are 0. They are held while `reset` is high and take effect immediately on assertion, including mid-count.
- Synchroniser, per bit: `sync1` <= `raw`; `sync2` <= `sync1`. No other logic reads `raw` or `sync1`.
- Debounce, per bit i, on each rising edge:
  - If `sync2[i] == switches[i]`: `cnt[i]` <= 0. Any glitch shorter than DEBOUNCE_CYCLES is discarded.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `switches[i]` <= `sync2[i]`, `cnt[i]` <= 0.
  - Else: `cnt[i]` <= `cnt[i]+1`.
- Latency: `raw[i]` changes before edge k and stays constant. `switches[i]` then updates at edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 edges counting edge k.
  - With DEBOUNCE_CYCLES=1, the update occurs at edge k+2.
- Counters never exceed DEBOUNCE_CYCLES-1 and never wrap.
- Bits are independent: each bit updates on its own schedule. Several bits may update on the same edge.
- `changed` is registered: it is 1 on the edge where one or more bits of `switches` update, otherwise 0. It is never high for two consecutive cycles unless updates occur on consecutive edges.
- `event_pending`, on each edge:
  - Set if any bit updates on that edge.
  - Else cleared if `ack`=1.
  - Else held.
  - Simultaneous update and `ack`: the set wins and `event_pending` stays 1.
  - `ack` while `event_pending`=0 has no effect.
- After reset with non-zero raw inputs: the bits that differ from 0 update after DEBOUNCE_CYCLES+2 edges and raise `changed`/`event_pending` normally. No special power-up suppression.
- No combinational path from any input to any output.

Test Plan:
- DEBOUNCE_CYCLES=4, `reset` pulsed, `raw`=8'd5 held -> `switches`=0 for 5 edges after reset release, then `switches`=8'd5 at the 6th edge. `changed`=1 for exactly one cycle; `event_pending`=1.
- `raw[0]` toggled 0->1->0 with a high time of 3 cycles (< DEBOUNCE_CYCLES), with `switches[0]`=0 -> `switches` unchanged, `changed` never asserted, counter returns to 0.
- Bouncing `raw[3]`: 1 cycle high, 1 low, 2 high, 1 low, then held high -> `switches[3]` goes 1 exactly 6 edges after the final rising transition is first sampled. One `changed` pulse only.
- `raw` 8'h00->8'hFF on one edge -> all 8 bits update on the same edge. A single one-cycle `changed` pulse; `switches`=8'hFF.
- `event_pending`=1, `ack`=1 for one cycle with no update -> `event_pending`=0 next edge. Repeat with `ack` coincident with an update edge -> `event_pending` remains 1.
- `reset` asserted asynchronously (mid-clock) while `cnt[2]`=2 and `switches`=8'h04 -> `switches`, `changed` and `event_pending` go 0 immediately, before the next edge. After release, re-debounce restarts from count 0.
